// File: rtl/project_pkg.sv
`default_nettype none
// ============================================================================
// Module   : project_pkg
// Brief    : Shared pixel and frame-count types for the video stream stages.
// Revision : 1.0 - initial release
// ============================================================================
package project_pkg;

    localparam int PIXEL_W     = 16;
    localparam int FRAME_CNT_W = 16;

    typedef logic [PIXEL_W-1:0]     pixel_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

endpackage
`default_nettype wire

// File: rtl/axis_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pipe_reg
// Brief    : Single-entry valid/ready register slice. The slot can be refilled
//            in the same cycle it drains, so a steady stream sees no bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pipe_reg #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Free when empty or when the current entry leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Load on upstream handshake, otherwise empty on downstream handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_video_decimator.sv
`default_nettype none
// ============================================================================
// Module   : axis_video_decimator
// Brief    : 2:1 horizontal and vertical decimation of an AXI4-Stream video
//            stream (tuser = start of frame, tlast = end of line), with sticky
//            line/frame structure error flag and output frame counter.
//            Build macro DECIM_AVG_EN: average horizontal pixel pairs on even
//            lines instead of dropping the odd pixel.
// Revision : 1.0 - initial release
// ============================================================================
module axis_video_decimator
    import project_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGTH = 480,
    parameter int DATA_W = PIXEL_W
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              err_sync,
    output frame_cnt_t        frame_cnt
);

    localparam int c_XW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int c_YW = (HEIGTH > 2) ? $clog2(HEIGTH) : 1;

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(WIDTH - 1);
    localparam logic [c_XW-1:0] c_X_PEN  = c_XW'(WIDTH - 2);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(HEIGTH - 1);

    logic [c_XW-1:0]   r_x;
    logic [c_YW-1:0]   r_y;
    logic              r_seen_sof;
    logic              r_err;
    frame_cnt_t        r_frame_cnt;

    logic [c_XW-1:0]   w_x;
    logic [c_YW-1:0]   w_y;
    logic              w_accept;
    logic              w_at_end;
    logic              w_line_end;
    logic              w_len_err;
    logic              w_sof_err;
    logic              w_fwd;
    logic              w_pipe_ready;
    logic [DATA_W-1:0] w_out_data;
    logic              w_out_user;
    logic              w_out_last;
    logic [DATA_W+1:0] w_m_payload;

    // A start-of-frame beat is itself the (0,0) pixel, so it overrides the counters.
    assign w_x        = s_axis_tuser ? '0 : r_x;
    assign w_y        = s_axis_tuser ? '0 : r_y;
    assign w_accept   = s_axis_tvalid && s_axis_tready;
    assign w_at_end   = (w_x == c_X_LAST);
    assign w_line_end = s_axis_tlast || w_at_end;
    // Early tlast and missing tlast are both a tlast/position disagreement.
    assign w_len_err  = (s_axis_tlast != w_at_end);
    // Before the first start of frame the position is meaningless, so no resync error.
    assign w_sof_err  = s_axis_tuser && r_seen_sof && ((r_x != '0) || (r_y != '0));

`ifdef DECIM_AVG_EN
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_user;
    logic [DATA_W:0]   w_sum;

    // Even lines: park the x-even pixel, emit the pair average on the x-odd beat.
    assign w_fwd      = w_x[0] && !w_y[0];
    assign w_sum      = {1'b0, r_hold} + {1'b0, s_axis_tdata};
    assign w_out_data = w_sum[DATA_W:1];
    assign w_out_user = r_hold_user;
    assign w_out_last = w_at_end;

    // Capture the x-even pixel of an even line together with its start-of-frame flag.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_user <= 1'b0;
        end else if (w_accept && !w_x[0] && !w_y[0]) begin
            r_hold      <= s_axis_tdata;
            r_hold_user <= (w_x == '0) && (w_y == '0);
        end
    end
`else
    // Keep only the even-x pixels of even lines.
    assign w_fwd      = !w_x[0] && !w_y[0];
    assign w_out_data = s_axis_tdata;
    assign w_out_user = (w_x == '0) && (w_y == '0);
    assign w_out_last = (w_x == c_X_PEN);
`endif

    // Dropped beats never wait; kept beats wait for a free output slot.
    assign s_axis_tready = !reset && (!w_fwd || w_pipe_ready);

    // Track pixel position, sticky structure error and completed frames.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_seen_sof  <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_accept) begin
            if (s_axis_tuser) begin
                r_seen_sof <= 1'b1;
            end
            if (w_len_err || w_sof_err) begin
                r_err <= 1'b1;
            end
            if (w_line_end) begin
                r_x <= '0;
                if (w_y == c_Y_LAST) begin
                    r_y         <= '0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end else begin
                    r_y <= w_y + 1'b1;
                end
            end else begin
                r_x <= w_x + 1'b1;
                r_y <= w_y;
            end
        end
    end

    axis_pipe_reg #(
        .W (DATA_W + 2)
    ) u_out_reg (
        .clk     (aclk),
        .rst     (reset),
        .i_valid (s_axis_tvalid && w_fwd),
        .o_ready (w_pipe_ready),
        .i_data  ({w_out_data, w_out_user, w_out_last}),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready),
        .o_data  (w_m_payload)
    );

    assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = w_m_payload;
    assign err_sync  = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/axis_video_decimator.md
# axis_video_decimator

Downstream of the camera-to-AXI-Stream capture stage. Consumes its 16-bit video stream (tuser = start of frame, tlast = end of line) and emits a 2:1 horizontally and vertically decimated stream in the same AXI4-Stream video format. Frame output is WIDTH/2 x HEIGTH/2. It also flags malformed line or frame structure so a preview or display path can run on the reduced frame.

## Interface
- WIDTH, 640, active pixels per input line; must be even.
- HEIGTH, 480, active lines per input frame; must be even.
- DATA_W, 16, pixel width in bits.
- aclk  in  1  stream clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_W  input pixel.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tuser  in  1  first pixel of frame.
- s_axis_tlast  in  1  last pixel of line.
- m_axis_tdata  out  DATA_W  decimated pixel.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  first output pixel of frame.
- m_axis_tlast  out  1  last output pixel of line.
- err_sync  out  1  sticky; set on any line-length or frame-length violation.
- frame_cnt  out  16  count of completed output frames; wraps at 65535 -> 0.

## Operation
- Input counters: x in 0..WIDTH-1 and y in 0..HEIGTH-1. They advance only on an accepted input beat (tvalid && tready).
- Accepted beat with tuser=1: x=0 and y=0 apply to that beat.
  - If the previous frame was incomplete (y != 0 or x != 0 before this beat, excluding the first frame after reset), set err_sync.
- Accepted beat with tlast=1 and x != WIDTH-1 (early tlast): set err_sync, x <= 0, y <= y+1.
- Beat at x == WIDTH-1 with tlast=0 (missing tlast): set err_sync and treat as line end.
- Line end: y wraps to 0 after HEIGTH-1. The wrap increments frame_cnt.
- Keep rule, default build: forward the beat iff x[0]==0 and y[0]==0. All other beats are accepted and discarded.
- Output sideband:
  - m_axis_tuser = 1 on the kept beat at x=0, y=0.
  - m_axis_tlast = 1 on the kept beat at x=WIDTH-2.
- s_axis_tready = 0 while reset is high.
- Discarded beats: tready = 1.
- Kept beats: tready = !m_axis_tvalid || m_axis_tready.
- Output holding: m_axis_* stays stable while tvalid && !tready.
- A tuser arriving mid-line does not flush a pending output beat; that beat completes unchanged.
- Reset mid-frame drops any pending output beat and clears all counters. The next tuser starts cleanly with no err_sync.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, err_sync=0, frame_cnt=0, x=0, y=0.
- Latency: an accepted kept input beat appears on m_axis in the next cycle.
- Throughput: one input beat per cycle when m_axis_tready is held high.
- Simultaneous accept and drain: a kept beat may be accepted in the same cycle the output register drains. There is no bubble.
- frame_cnt and err_sync update in the cycle after the triggering beat is accepted.

## Configuration
- DECIM_AVG_EN defined:
  - Horizontal pair averaging replaces pixel dropping.
  - On even lines, the x-even pixel is held in a register.
  - On x-odd, the block emits (held + current) >> 1, computed with a DATA_W+1 sum and truncated to DATA_W.
  - tuser is taken from the held x=0 beat and output with the x=1 result.
  - tlast is output on the beat from x=WIDTH-1.
  - Odd lines are discarded.
- DECIM_AVG_EN undefined: plain decimation as in Operation; no hold register is synthesised.

## Structure
- project_pkg holds:
  - pixel_t typedef: logic [DATA_W-1:0] with DATA_W = 16.
  - The 16-bit frame-count type.
- Sub-module axis_pipe_reg: a single-entry valid/ready output register carrying {tdata, tuser, tlast}. It is reusable by other stream stages.
- Counters, keep logic, error detection and the averaging path stay in the top module.

## Test plan
All scenarios use WIDTH=8, HEIGTH=4.
- Nominal frame: pixel value = 16*y + x, tready=1.
  - Required output: 8 beats, values 0,2,4,6,32,34,36,38.
  - tuser on value 0; tlast on values 6 and 38; frame_cnt=1; err_sync=0.
- Backpressure: same frame with m_axis_tready toggling 1,0,0,1 repeatedly.
  - Identical 8-beat output; no beat is lost or duplicated; tdata is stable while stalled.
- Early tlast: tlast on x=5 of line 0.
  - err_sync=1 one cycle later; the next beat is counted as y=1.
  - The output line for y=0 has no tlast at x=6.
- Resync: tuser mid-frame at y=2, x=3.
  - err_sync=1; output restarts with tuser on that beat; frame_cnt is not incremented.
- DECIM_AVG_EN with pixel value = 16*y + x:
  - Line 0 yields 0,2,4,6, from (0+1)>>1 = 0, (2+3)>>1 = 2, and so on.
  - Line 2 yields 32,34,36,38.
  - Beat from x=1: tuser=1. Beat from x=7: tlast=1.
- Reset mid-frame at y=1: all outputs return to their reset values. The next full frame matches the nominal result with err_sync=0.
